// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional packet lock (keeps a requester's bytes contiguous): define UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_send,
  input  logic                          tx_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_REQ-1:0]    r_ack;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_send;
  logic [ID_W-1:0]       r_grant_id;
  logic                  r_active;
  logic [ID_W-1:0]       r_rr_ptr;

  logic [NUM_REQ-1:0]    w_ack_nxt;
  logic [DATA_WIDTH-1:0] w_tx_data_nxt;
  logic                  w_tx_send_nxt;
  logic [ID_W-1:0]       w_grant_id_nxt;
  logic                  w_active_nxt;
  logic [ID_W-1:0]       w_rr_ptr_nxt;

  logic [ID_W-1:0]       w_rr_win;
  logic                  w_rr_found;
  logic [ID_W-1:0]       w_win;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_start;
  logic                  w_done;

  // Round-robin pick: first set req bit after r_rr_ptr, wrapping.
  always_comb begin
    int v_idx;
    w_rr_found = 1'b0;
    w_rr_win   = '0;
    v_idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_rr_found && req[ID_W'(v_idx)]) begin
        w_rr_found = 1'b1;
        w_rr_win   = ID_W'(v_idx);
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic r_lock_hold;
  logic w_lock_win;

  assign w_lock_win = r_lock_hold && req[r_grant_id];
  assign w_win      = w_lock_win ? r_grant_id : w_rr_win;

  // Lock is sampled from the finishing owner; dropped once it stops requesting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lock_hold <= 1'b0;
    end else if (w_done) begin
      r_lock_hold <= req_lock[r_grant_id];
    end else if (r_state == S_IDLE && !req[r_grant_id]) begin
      r_lock_hold <= 1'b0;
    end
  end
`else
  assign w_win = w_rr_win;
`endif

  assign w_win_data = req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
  assign w_start    = (r_state == S_IDLE) && (|req) && !tx_busy;
  assign w_done     = (r_state == S_WAIT_DONE) && !tx_busy;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (w_start) w_state_nxt = S_LAUNCH;
      S_LAUNCH:    w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output next values: launch loads everything, data/grant hold otherwise.
  always_comb begin
    w_ack_nxt      = '0;
    w_tx_send_nxt  = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_grant_id_nxt = r_grant_id;
    w_active_nxt   = r_active;
    w_rr_ptr_nxt   = r_rr_ptr;
    if (w_start) begin
      w_ack_nxt[w_win] = 1'b1;
      w_tx_send_nxt    = 1'b1;
      w_tx_data_nxt    = w_win_data;
      w_grant_id_nxt   = w_win;
      w_active_nxt     = 1'b1;
      w_rr_ptr_nxt     = w_win;
    end
    if (w_done) begin
      w_active_nxt = 1'b0;
    end
  end

  // Output registers; reset points rr_ptr at the last slot so slot 0 wins first.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ack      <= '0;
      r_tx_data  <= '0;
      r_tx_send  <= 1'b0;
      r_grant_id <= '0;
      r_active   <= 1'b0;
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else begin
      r_ack      <= w_ack_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_send  <= w_tx_send_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_active   <= w_active_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

  assign ack      = r_ack;
  assign tx_data  = r_tx_data;
  assign tx_send  = r_tx_send;
  assign grant_id = r_grant_id;
  assign active   = r_active;

endmodule
